// File: rtl/csi_hs_burst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csi_hs_burst_sequencer_pkg
// Description : Types and constants shared by the D-PHY HS burst sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package csi_hs_burst_sequencer_pkg;

    localparam int N_DATA_LANES         = 2;
    localparam int HS_TX_WORD_BIT_WIDTH = 8;

    localparam int DEF_T_LPX        = 4;
    localparam int DEF_T_HS_PREPARE = 3;
    localparam int DEF_T_HS_ZERO    = 10;
    localparam int DEF_T_HS_TRAIL   = 6;
    localparam int DEF_T_HS_EXIT    = 8;

    typedef logic [HS_TX_WORD_BIT_WIDTH-1:0] t_hs_word;
    typedef t_hs_word [N_DATA_LANES-1:0]     t_data_lane_bus;

    localparam t_hs_word HS_SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        LP00 = 3'd0,
        LP01 = 3'd1,
        LP10 = 3'd2,
        LP11 = 3'd3,
        HS0  = 3'd4,
        HS1  = 3'd5,
        HS   = 3'd6
    } t_phy_line_states;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LPX    = 3'd1,
        PREP   = 3'd2,
        HSZERO = 3'd3,
        SYNC   = 3'd4,
        DATA   = 3'd5,
        TRAIL  = 3'd6,
        EXIT   = 3'd7
    } t_hs_seq_state;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csi_hs_burst_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : csi_hs_burst_sequencer_if
// Description : Payload stream in, per-lane HS words and line states out.
// Revision    : 1.0 - initial release
// ============================================================================
interface csi_hs_burst_sequencer_if;
    import csi_hs_burst_sequencer_pkg::*;

    t_data_lane_bus   s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    t_data_lane_bus   hs_data;
    t_phy_line_states data_line_state [N_DATA_LANES];
    t_phy_line_states clk_line_state;
    logic             busy;
    logic             done;
    logic             underrun;

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready, hs_data, data_line_state, clk_line_state, busy, done, underrun
    );

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready, hs_data, data_line_state, clk_line_state, busy, done, underrun
    );

endinterface
`default_nettype wire

// File: rtl/csi_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : csi_seq_timer
// Description : Loadable down-counter; expired while the count sits at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module csi_seq_timer #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] load_val_i,
    output logic                  expired_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/csi_hs_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : csi_hs_burst_sequencer
// Description : Sequences one D-PHY HS burst (LP request, HS-zero, sync,
//               payload, trail, exit) across all data lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module csi_hs_burst_sequencer
    import csi_hs_burst_sequencer_pkg::*;
#(
    parameter int T_LPX        = DEF_T_LPX,
    parameter int T_HS_PREPARE = DEF_T_HS_PREPARE,
    parameter int T_HS_ZERO    = DEF_T_HS_ZERO,
    parameter int T_HS_TRAIL   = DEF_T_HS_TRAIL,
    parameter int T_HS_EXIT    = DEF_T_HS_EXIT
) (
    input  wire logic               clk,
    input  wire logic               rst,
    csi_hs_burst_sequencer_if.slave bus
);

    localparam int T_MAX = max_int(max_int(max_int(T_LPX, T_HS_PREPARE),
                                           max_int(T_HS_ZERO, T_HS_TRAIL)), T_HS_EXIT);
    localparam int TMR_W = $clog2(T_MAX) + 1;
    localparam int W     = HS_TX_WORD_BIT_WIDTH;

    if (T_LPX < 1 || T_HS_PREPARE < 1 || T_HS_ZERO < 1 || T_HS_TRAIL < 1 || T_HS_EXIT < 1)
    begin : g_param_check
        $error("csi_hs_burst_sequencer: every T_* timing parameter must be >= 1");
    end

    t_hs_seq_state    state_q, state_d;
    t_phy_line_states line_q [N_DATA_LANES];
    t_phy_line_states line_d [N_DATA_LANES];
    t_phy_line_states clk_line_q, clk_line_d;
    t_data_lane_bus   hs_data_q, hs_data_d;
    logic [N_DATA_LANES-1:0] last_msb_q, last_msb_d;
    logic             s_ready_q, s_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_expired;
    logic             hs_fire;

    assign hs_fire = (state_q == DATA) && bus.s_valid && s_ready_q;

    csi_seq_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            for (int i = 0; i < N_DATA_LANES; i++) begin
                line_q[i] <= LP11;
            end
            clk_line_q <= LP11;
            hs_data_q  <= '0;
            last_msb_q <= '0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            clk_line_q <= clk_line_d;
            hs_data_q  <= hs_data_d;
            last_msb_q <= last_msb_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    // The timer is reloaded on every state entry so each phase lasts exactly T_x cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.s_valid) state_d = LPX;
            LPX:     if (tmr_expired) state_d = PREP;
            PREP:    if (tmr_expired) state_d = HSZERO;
            HSZERO:  if (tmr_expired) state_d = SYNC;
            SYNC:    state_d = DATA;
            DATA:    if (!bus.s_valid || (hs_fire && bus.s_last)) state_d = TRAIL;
            TRAIL:   if (tmr_expired) state_d = EXIT;
            EXIT:    if (tmr_expired) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        tmr_load     = (state_d != state_q);
        tmr_load_val = '0;
        case (state_d)
            LPX:     tmr_load_val = TMR_W'(T_LPX - 1);
            PREP:    tmr_load_val = TMR_W'(T_HS_PREPARE - 1);
            HSZERO:  tmr_load_val = TMR_W'(T_HS_ZERO - 1);
            TRAIL:   tmr_load_val = TMR_W'(T_HS_TRAIL - 1);
            EXIT:    tmr_load_val = TMR_W'(T_HS_EXIT - 1);
            default: tmr_load_val = '0;
        endcase
    end

    // Line outputs follow the state one cycle later; s_ready looks ahead so the
    // first DATA cycle can already accept a word.
    always_comb begin
        line_d     = line_q;
        clk_line_d = clk_line_q;
        hs_data_d  = hs_data_q;
        last_msb_d = last_msb_q;
        s_ready_d  = (state_d == DATA);
        busy_d     = (state_q != IDLE);
        done_d     = 1'b0;
        underrun_d = 1'b0;

        case (state_q)
            IDLE, EXIT: begin
                for (int i = 0; i < N_DATA_LANES; i++) line_d[i] = LP11;
                clk_line_d = LP11;
                hs_data_d  = '0;
                done_d     = (state_q == EXIT) && tmr_expired;
            end
            LPX: begin
                for (int i = 0; i < N_DATA_LANES; i++) line_d[i] = LP01;
                clk_line_d = LP01;
                hs_data_d  = '0;
            end
            PREP: begin
                for (int i = 0; i < N_DATA_LANES; i++) line_d[i] = LP00;
                clk_line_d = LP00;
                hs_data_d  = '0;
            end
            HSZERO: begin
                for (int i = 0; i < N_DATA_LANES; i++) line_d[i] = HS0;
                clk_line_d = HS0;
                hs_data_d  = '0;
            end
            SYNC: begin
                for (int i = 0; i < N_DATA_LANES; i++) begin
                    line_d[i]     = HS1;
                    hs_data_d[i]  = HS_SYNC_BYTE;
                    last_msb_d[i] = HS_SYNC_BYTE[W-1];
                end
                clk_line_d = HS0;
            end
            DATA: begin
                clk_line_d = HS0;
                underrun_d = !bus.s_valid;
                if (hs_fire) begin
                    for (int i = 0; i < N_DATA_LANES; i++) begin
                        line_d[i]     = HS;
                        hs_data_d[i]  = bus.s_data[i];
                        last_msb_d[i] = bus.s_data[i][W-1];
                    end
                end
            end
            TRAIL: begin
                // Trail holds the inverse of the last bit sent on each lane.
                for (int i = 0; i < N_DATA_LANES; i++) begin
                    line_d[i]    = last_msb_q[i] ? HS0 : HS1;
                    hs_data_d[i] = {W{~last_msb_q[i]}};
                end
                clk_line_d = HS0;
            end
            default: begin
                for (int i = 0; i < N_DATA_LANES; i++) line_d[i] = LP11;
                clk_line_d = LP11;
            end
        endcase
    end

    assign bus.s_ready         = s_ready_q;
    assign bus.hs_data         = hs_data_q;
    assign bus.data_line_state = line_q;
    assign bus.clk_line_state  = clk_line_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.underrun        = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_csi_hs_burst_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_csi_hs_burst_sequencer
// Description : Directed self-checking bench for the HS burst sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csi_hs_burst_sequencer;
    import csi_hs_burst_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csi_hs_burst_sequencer_if bus_if ();

    csi_hs_burst_sequencer #(
        .T_LPX        (4),
        .T_HS_PREPARE (3),
        .T_HS_ZERO    (10),
        .T_HS_TRAIL   (6),
        .T_HS_EXIT    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] wq [0:3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " line0"}, 32'(bus_if.data_line_state[0]), 32'(LP11));
        check({tag, " line1"}, 32'(bus_if.data_line_state[1]), 32'(LP11));
        check({tag, " clk"},   32'(bus_if.clk_line_state),     32'(LP11));
        check({tag, " hs"},    32'(bus_if.hs_data),            32'h0);
        check({tag, " ready"}, 32'(bus_if.s_ready),            32'h0);
        check({tag, " busy"},  32'(bus_if.busy),               32'h0);
        check({tag, " done"},  32'(bus_if.done),               32'h0);
        check({tag, " undr"},  32'(bus_if.underrun),           32'h0);
    endtask

    // k words offered from wq; drop: no s_last, s_valid falls after k words.
    // Edge 0 is the first edge sampling s_valid in IDLE.
    task automatic run_burst(input string tag, input int k, input bit drop, input bit hold_valid);
        int d, ptr;
        bit acc, chk_hs;
        logic [15:0] lw, exp_hs;
        t_phy_line_states ex0, ex1, exc;
        d   = drop ? k + 1 : k;
        ptr = 0;
        lw  = wq[k-1];
        for (int e = 0; e <= 32 + d; e++) begin
            if (ptr < k) begin
                bus_if.s_valid = 1'b1;
                bus_if.s_data  = wq[ptr];
                bus_if.s_last  = !drop && (ptr == k - 1);
            end else begin
                bus_if.s_valid = hold_valid;
                bus_if.s_data  = 16'hA55A;
                bus_if.s_last  = 1'b0;
            end
            acc = bus_if.s_valid && bus_if.s_ready;
            tick();
            if (acc) ptr++;

            chk_hs = 1'b1;
            exp_hs = 16'h0000;
            if (e == 0)              begin ex0 = LP11; ex1 = LP11; chk_hs = 1'b0; end
            else if (e <= 4)         begin ex0 = LP01; ex1 = LP01; chk_hs = 1'b0; end
            else if (e <= 7)         begin ex0 = LP00; ex1 = LP00; chk_hs = 1'b0; end
            else if (e <= 17)        begin ex0 = HS0;  ex1 = HS0; end
            else if (e == 18)        begin ex0 = HS1;  ex1 = HS1;  exp_hs = 16'hB8B8; end
            else if (e <= 18 + k)    begin ex0 = HS;   ex1 = HS;   exp_hs = wq[e-19]; end
            else if (e < 19 + d)     begin ex0 = HS;   ex1 = HS;   exp_hs = lw; end
            else if (e <= 24 + d) begin
                ex0 = lw[7]  ? HS0 : HS1;
                ex1 = lw[15] ? HS0 : HS1;
                exp_hs = {(lw[15] ? 8'h00 : 8'hFF), (lw[7] ? 8'h00 : 8'hFF)};
            end
            else                     begin ex0 = LP11; ex1 = LP11; chk_hs = 1'b0; end

            if (e == 0)              exc = LP11;
            else if (e <= 4)         exc = LP01;
            else if (e <= 7)         exc = LP00;
            else if (e <= 24 + d)    exc = HS0;
            else                     exc = LP11;

            check($sformatf("%s@%0d line0", tag, e), 32'(bus_if.data_line_state[0]), 32'(ex0));
            check($sformatf("%s@%0d line1", tag, e), 32'(bus_if.data_line_state[1]), 32'(ex1));
            check($sformatf("%s@%0d clk", tag, e), 32'(bus_if.clk_line_state), 32'(exc));
            if (chk_hs)
                check($sformatf("%s@%0d hs", tag, e), 32'(bus_if.hs_data), 32'(exp_hs));
            check($sformatf("%s@%0d ready", tag, e), 32'(bus_if.s_ready),
                  32'((e >= 18 && e <= 17 + d) ? 1 : 0));
            check($sformatf("%s@%0d done", tag, e), 32'(bus_if.done), 32'((e == 32 + d) ? 1 : 0));
            check($sformatf("%s@%0d undr", tag, e), 32'(bus_if.underrun),
                  32'((drop && e == 19 + k) ? 1 : 0));
            if (e >= 1 && e <= 31 + d)
                check($sformatf("%s@%0d busy", tag, e), 32'(bus_if.busy), 32'h1);
        end
        check({tag, " words"}, 32'(ptr), 32'(k));
    endtask

    initial begin
        rst            = 1'b1;
        bus_if.s_valid = 1'b0;
        bus_if.s_last  = 1'b0;
        bus_if.s_data  = '0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;

        // Two words; last word lane0=0x80, lane1=0x01 sets opposite trails.
        wq[0] = 16'h2211;
        wq[1] = 16'h0180;
        run_burst("t1", 2, 1'b0, 1'b0);

        // One word, then s_valid drops in the next DATA cycle.
        wq[0] = 16'hC312;
        run_burst("t3", 1, 1'b1, 1'b0);

        // Single-word burst, s_valid kept high through EXIT; next burst follows at once.
        wq[0] = 16'h7FFF;
        run_burst("t6", 1, 1'b0, 1'b1);
        wq[0] = 16'h4455;
        wq[1] = 16'h99AA;
        run_burst("t5", 2, 1'b0, 1'b0);

        // Reset during HS-zero, then a full-length restart.
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = 16'h1234;
        bus_if.s_last  = 1'b0;
        repeat (11) tick();
        check("t4 pre line0", 32'(bus_if.data_line_state[0]), 32'(HS0));
        rst = 1'b1;
        tick();
        check_idle_outputs("t4 rst");
        rst = 1'b0;
        wq[0] = 16'h0081;
        run_burst("t4", 1, 1'b0, 1'b0);

        tick();
        check("end busy", 32'(bus_if.busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
